// File: rtl/pool2_maxpool_write.sv
// pool2_maxpool_write: 2x2 signed max-pool of conv2 reads, written sequentially into the 4x4 pool2 memory.
// Define POOL2_RELU_EN to clamp negative maxima to zero before the write (fused ReLU).
module pool2_maxpool_write #(
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1,
  parameter int N_WIN  = 16,
  parameter int WA_W   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] din0,
  input  logic signed [DATA_W-1:0] din1,
  input  logic signed [DATA_W-1:0] din2,
  input  logic signed [DATA_W-1:0] din3,
  output logic                     wr_en,
  output logic [WA_W-1:0]          wr_addr,
  output logic signed [DATA_W-1:0] wr_data,
  output logic                     busy,
  output logic                     done
);
  localparam int AC_W = $clog2(N_WIN + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;
  logic [AC_W-1:0] acc_cnt;
  logic [RD_LAT-1:0] vp;
  logic s1_v, acc, last_wr;
  logic signed [DATA_W-1:0] m01, m23, mx, res;
  assign acc     = in_valid && enable && state == RUN && acc_cnt < AC_W'(N_WIN);
  assign last_wr = wr_en && wr_addr == WA_W'(N_WIN - 1);
  assign mx      = m01 > m23 ? m01 : m23;
`ifdef POOL2_RELU_EN
  assign res = mx[DATA_W-1] ? '0 : mx;
`else
  assign res = mx;
`endif
  assign busy = state == RUN || state == DRAIN;
  assign done = state == DONE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      acc_cnt <= '0;
      vp      <= '0;
      s1_v    <= 1'b0;
      m01     <= '0;
      m23     <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state <= state == IDLE && enable ? RUN :
               state == RUN && acc_cnt == AC_W'(N_WIN) ? DRAIN :
               state == DRAIN && last_wr ? DONE : state;
      if (acc) acc_cnt <= acc_cnt + 1'b1;
      for (int i = RD_LAT - 1; i > 0; i--) vp[i] <= vp[i-1];
      vp[0] <= acc;
      s1_v  <= vp[RD_LAT-1];
      m01   <= din0 > din1 ? din0 : din1;
      m23   <= din2 > din3 ? din2 : din3;
      wr_en <= s1_v && busy;
      if (s1_v) wr_data <= res;
      // write index saturates at the last address rather than wrapping
      if (wr_en && !last_wr) wr_addr <= wr_addr + 1'b1;
    end
  end
endmodule

// File: tb/tb_pool2_maxpool_write.sv
// tb_pool2_maxpool_write: directed checks of pool2_maxpool_write with RD_LAT=1 and RD_LAT=3 instances.
module tb_pool2_maxpool_write;
  logic clk = 1'b0, reset = 1'b1;
  logic en = 1'b0, iv = 1'b0, en3 = 1'b0, iv3 = 1'b0;
  logic [15:0] w0 = '0, w1 = '0, w2 = '0, w3 = '0, d0, d1, d2, d3;
  logic [63:0] v3 = '0, p3 [3];
  logic [15:0] e0, e1, e2, e3;
  logic        wr_en, busy, done, wr_en3, busy3, done3;
  logic [3:0]  wr_addr, wr_addr3;
  logic [15:0] wr_data, wr_data3;
  logic [3:0]  la [$];
  logic [15:0] ld [$];
  int          lc [$];
  int cyc = 0, n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) {d0, d1, d2, d3} <= {w0, w1, w2, w3};
  always @(posedge clk) begin
    p3[0] <= v3;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign {e0, e1, e2, e3} = p3[2];
  always @(negedge clk) if (wr_en) begin
    la.push_back(wr_addr);
    ld.push_back(wr_data);
    lc.push_back(cyc);
  end

  pool2_maxpool_write #(.RD_LAT(1)) dut (
    .clk(clk), .reset(reset), .enable(en), .in_valid(iv),
    .din0(d0), .din1(d1), .din2(d2), .din3(d3),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done));
  pool2_maxpool_write #(.RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .enable(en3), .in_valid(iv3),
    .din0(e0), .din1(e1), .din2(e2), .din3(e3),
    .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3), .busy(busy3), .done(done3));

  task automatic step();
    @(negedge clk);
  endtask

  task automatic win(input int a, input int b, input int c, input int d);
    w0 = 16'(a); w1 = 16'(b); w2 = 16'(c); w3 = 16'(d);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic restart();
    iv = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    la.delete(); ld.delete(); lc.delete();
    step();
  endtask

  initial begin
    step();
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    reset = 1'b0;
    en = 1'b1;
    step();
    chk("run_busy", 32'(busy), 1);
    // single window, latency 3
    win(3, -7, 12, 5); iv = 1'b1; step(); iv = 1'b0;
    chk("a_lat1", 32'(wr_en), 0);
    step();
    chk("a_lat2", 32'(wr_en), 0);
    step();
    chk("a_wr_en", 32'(wr_en), 1);
    chk("a_addr", 32'(wr_addr), 0);
    chk("a_data", 32'(wr_data), 12);
    // all-negative window
    win(-4, -9, -2, -8); iv = 1'b1; step(); iv = 1'b0;
    chk("a_pulse", 32'(wr_en), 0);
    step(); step();
    chk("b_wr_en", 32'(wr_en), 1);
    chk("b_addr", 32'(wr_addr), 1);
`ifdef POOL2_RELU_EN
    chk("b_data", 32'(wr_data), 0);
`else
    chk("b_data", 32'(wr_data), 32'h0000fffe);
`endif
    // 16 back-to-back windows plus an ignored 17th
    restart();
    for (int i = 0; i < 17; i++) begin
      win(-20, i, -1 - i, i - 1); iv = 1'b1; step();
    end
    iv = 1'b0;
    step();
    chk("f_last_en", 32'(wr_en), 1);
    chk("f_last_addr", 32'(wr_addr), 15);
    chk("f_last_data", 32'(wr_data), 15);
    chk("f_done_early", 32'(done), 0);
    step();
    chk("f_done", 32'(done), 1);
    chk("f_busy", 32'(busy), 0);
    chk("f_after_en", 32'(wr_en), 0);
    repeat (4) step();
    chk("f_count", 32'(la.size()), 16);
    chk("f_hold_addr", 32'(wr_addr), 15);
    for (int i = 0; i < 16 && i < la.size(); i++) begin
      chk($sformatf("f_addr%0d", i), 32'(la[i]), 32'(i));
      chk($sformatf("f_data%0d", i), 32'(ld[i]), 32'(i));
      chk($sformatf("f_cyc%0d", i), 32'(lc[i] - lc[0]), 32'(i));
    end
    // enable gap after window 6
    restart();
    for (int i = 0; i < 7; i++) begin
      win(-20, 100 + i, -1, 99 + i); iv = 1'b1; step();
    end
    en = 1'b0;
    win(7777, 7777, 7777, 7777);
    repeat (5) step();
    en = 1'b1;
    for (int i = 7; i < 16; i++) begin
      win(-20, 100 + i, -1, 99 + i); step();
    end
    iv = 1'b0;
    repeat (6) step();
    chk("g_count", 32'(la.size()), 16);
    for (int i = 0; i < 16 && i < la.size(); i++) begin
      chk($sformatf("g_addr%0d", i), 32'(la[i]), 32'(i));
      chk($sformatf("g_data%0d", i), 32'(ld[i]), 32'(100 + i));
    end
    if (la.size() > 7) chk("g_gap", 32'(lc[7] - lc[6]), 6);
    chk("g_done", 32'(done), 1);
    // reset with two windows in flight
    restart();
    for (int i = 0; i < 11; i++) begin
      win(-20, 200 + i, -1, 199 + i); iv = 1'b1; step();
    end
    iv = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("r_wr_en", 32'(wr_en), 0);
    chk("r_wr_addr", 32'(wr_addr), 0);
    chk("r_done", 32'(done), 0);
    chk("r_busy", 32'(busy), 0);
    chk("r_count", 32'(la.size()), 9);
    step();
    reset = 1'b0;
    la.delete(); ld.delete(); lc.delete();
    step();
    for (int i = 0; i < 16; i++) begin
      win(-20, 300 + i, -1, 299 + i); iv = 1'b1; step();
    end
    iv = 1'b0;
    repeat (6) step();
    chk("r2_count", 32'(la.size()), 16);
    if (la.size() == 16) begin
      chk("r2_addr0", 32'(la[0]), 0);
      chk("r2_data0", 32'(ld[0]), 300);
      chk("r2_addr15", 32'(la[15]), 15);
      chk("r2_data15", 32'(ld[15]), 315);
    end
    chk("r2_done", 32'(done), 1);
    // RD_LAT=3 instance, tie-heavy window
    en3 = 1'b1;
    step();
    v3 = {16'd100, 16'd100, 16'hffff, 16'd100}; iv3 = 1'b1; step(); iv3 = 1'b0;
    repeat (3) step();
    chk("l3_lat4", 32'(wr_en3), 0);
    step();
    chk("l3_wr_en", 32'(wr_en3), 1);
    chk("l3_addr", 32'(wr_addr3), 0);
    chk("l3_data", 32'(wr_data3), 100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pool2_maxpool_write.md
Name: pool2_maxpool_write

Overview:
- Downstream consumer of the conv2 output-memory read addresser.
- Each cycle, the addresser presents four addresses forming one 2x2 window of the 8x8 conv2 feature map. This block takes the four words returned by the memory and reduces them to their signed maximum.
- It writes the result sequentially into the 4x4 pool2 memory (addresses 0..15) and raises done after the 16th write.

Parameters:
- DATA_W, 16, width of each feature-map word (signed two's complement).
- RD_LAT, 1, read latency of the conv2 output memory in cycles (1..4 supported).
- N_WIN, 16, number of pooling windows per feature map.
- WA_W, 4, pool2 write-address width (clog2(N_WIN)).

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- enable  input  1  layer enable; gates acceptance of new windows
- in_valid  input  1  addresser presented a new 2x2 address set this cycle
- din0  input  DATA_W  word at addr0 (top-left), valid RD_LAT cycles after in_valid
- din1  input  DATA_W  word at addr1 (top-right)
- din2  input  DATA_W  word at addr2 (bottom-left)
- din3  input  DATA_W  word at addr3 (bottom-right)
- wr_en  output  1  pool2 memory write strobe
- wr_addr  output  WA_W  pool2 memory write address
- wr_data  output  DATA_W  pooled value
- busy  output  1  high in RUN or DRAIN
- done  output  1  sticky; high in DONE

Behaviour:
- Reset values: wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0. FSM=IDLE, accept counter=0, valid pipeline cleared.
- Reset mid-operation discards all in-flight windows immediately.
- FSM states:
  - IDLE -> RUN when enable=1.
  - RUN -> DRAIN when the accept counter reaches N_WIN.
  - DRAIN -> DONE on the cycle the N_WIN-th write is issued.
  - DONE holds until reset.
- Acceptance: a window is accepted when in_valid=1, enable=1, state=RUN, and accept counter < N_WIN. Accept counter increments by 1 per accepted window. in_valid is ignored in IDLE, DRAIN, DONE, or when enable=0.
- Valid pipeline: an accepted window's token shifts through an RD_LAT-deep register chain. It aligns with din0..3 at cycle t+RD_LAT, where t is the acceptance cycle.
- Compare stage 1, registered at t+RD_LAT+1:
  - m01 = signed max(din0, din1)
  - m23 = signed max(din2, din3)
- Compare stage 2, registered at t+RD_LAT+2: wr_data = signed max(m01, m23) and wr_en=1 for exactly one cycle.
- Total latency from in_valid to wr_en is RD_LAT+2 cycles. Throughput is one window per cycle, no bubbles.
- Ties: equal values produce that value; selection order is irrelevant.
- Write addressing: wr_addr presents the current write index while wr_en=1. The write index increments by 1 after each write and never wraps past N_WIN-1: after the 16th write it holds at 15.
- Deasserting enable mid-RUN blocks new acceptances only; in-flight windows still complete and are written. Re-asserting enable resumes acceptance with the counters unchanged.
- done rises in the cycle after the final wr_en pulse and stays high until reset. busy is low in IDLE and DONE.
- No write ever occurs in IDLE or DONE.

Optional Feature:
- Macro POOL2_RELU_EN.
- Defined: stage 2 output is clamped so any negative max becomes 0 before wr_data is registered (fused ReLU). Latency is unchanged.
- Undefined: raw signed max is written; negative values pass through.

Test Plan:
- Single window, RD_LAT=1, din={3,-7,12,5} -> wr_en pulse 3 cycles after in_valid, wr_addr=0, wr_data=12.
- All-negative window {-4,-9,-2,-8} -> wr_data=-2 without POOL2_RELU_EN; wr_data=0 with it.
- 16 back-to-back in_valid pulses with distinct maxima 0..15 -> 16 consecutive wr_en pulses, wr_addr 0..15, wr_data matches each window; done=1 on the following cycle; a 17th in_valid causes no write.
- enable dropped for 5 cycles after window 6 while in_valid stays high -> windows 0..6 are written; no writes are generated from in_valid during the gap; resumption continues at wr_addr=7; total writes = 16.
- Reset asserted while 2 windows are in flight (after 9 writes) -> wr_en=0 immediately, wr_addr=0, done=0; a new run afterwards writes 16 fresh words starting at address 0.
- RD_LAT=3, window {100,100,-1,100} -> wr_en 5 cycles after in_valid, wr_data=100.
